// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, clock-phase constants and defaults
// used by both the PISO transmitter and the SIPO receiver.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  // Receiver sampling edge: 0 = SCLK rise, 1 = SCLK fall.
  localparam logic C_PH_RISE = 1'b0;
  localparam logic C_PH_FALL = 1'b1;

  localparam int D_PACK_DEFAULT  = 8;
  localparam int CLK_DIV_DEFAULT = 4;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle TICK every CLK_DIV enabled cycles.
// The counter is held at zero while disabled so every frame starts phase-aligned.
module spi_clk_div #(
  parameter int CLK_DIV = spi_pkg::CLK_DIV_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic EN,
  output logic TICK
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: state is updated with non-blocking assignments under an async reset so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (!EN || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/spi_piso_tx.sv
// SPI parallel-in serial-out transmitter: accepts a word on a valid/ready
// handshake and shifts it out LSB-first under CS_N with a divided SCLK.
module spi_piso_tx
  import spi_pkg::*;
#(
  parameter int D_PACK  = D_PACK_DEFAULT,
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [D_PACK-1:0] PAR_IN,
  input  logic              C_PH,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  output logic              SCLK,
  output logic              DATA_OUT,
  output logic              CS_N,
  output logic              BUSY,
  output logic              DONE
);

  localparam int               CNT_W    = $clog2(D_PACK + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(D_PACK);

  spi_state_t        state;
  logic [D_PACK-1:0] shreg;
  logic              mode;
  logic [CNT_W-1:0]  bit_cnt;
  logic              tick;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .CLK  (CLK),
    .RST_N(RST_N),
    .EN   (state != ST_IDLE),
    .TICK (tick)
  );

  assign LOAD_READY = (state == ST_IDLE);
  assign BUSY       = (state != ST_IDLE);

  // shreg[0] always mirrors DATA_OUT; advancing moves the next bit into both.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      mode     <= C_PH_RISE;
      bit_cnt  <= '0;
      SCLK     <= 1'b0;
      CS_N     <= 1'b1;
      DATA_OUT <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (LOAD_VALID) begin
            shreg    <= PAR_IN;
            mode     <= C_PH;
            bit_cnt  <= '0;
            CS_N     <= 1'b0;
            DATA_OUT <= PAR_IN[0];
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (tick) begin
            SCLK  <= 1'b1;
            state <= ST_SHIFT;
            if (mode == C_PH_RISE) bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            if (SCLK) begin
              SCLK <= 1'b0;
              if (mode == C_PH_FALL) begin
                bit_cnt <= bit_cnt + 1'b1;
              end else if (bit_cnt != BIT_LAST) begin
                DATA_OUT <= shreg[1];
                shreg    <= {1'b0, shreg[D_PACK-1:1]};
              end
            end else if (bit_cnt == BIT_LAST) begin
              // All sampling edges seen and SCLK is low: frame body complete.
              state <= ST_HOLD;
            end else begin
              SCLK <= 1'b1;
              if (mode == C_PH_RISE) begin
                bit_cnt <= bit_cnt + 1'b1;
              end else begin
                DATA_OUT <= shreg[1];
                shreg    <= {1'b0, shreg[D_PACK-1:1]};
              end
            end
          end
        end

        ST_HOLD: begin
          if (tick) begin
            CS_N     <= 1'b1;
            DATA_OUT <= 1'b0;
            DONE     <= 1'b1;
            state    <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (tick) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
